// File: rtl/imem_load_pkg.sv
// Shared types and constants for the program-memory load controller.
package imem_load_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/imem_load_ctrl.sv
// Shares the fetch-stage program memory between the fetch path and a streaming
// loader; restarts the pipeline from address 0 once a load completes.
//
// state | meaning
// LOAD  | fetch held, loader words written to consecutive word addresses
// DRAIN | one cycle: PC reset and decode flush pulses
// RUN   | fetch owns the memory port; load_start requests a reload
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int word_width    = 32,
    parameter int address_width = 32,
    parameter int no_words      = 64,
    parameter bit boot_load     = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic                               ld_valid,
    input  logic [word_width-1:0]              ld_data,
    input  logic                               ld_last,
    output logic                               ld_ready,
    input  logic [address_width-1:0]           fetch_addr,
    output logic [address_width-1:0]           mem_addr,
    output logic                               mem_we,
    output logic [word_width-1:0]              mem_wr_data,
    output logic                               fetch_hold,
    output logic                               pc_reset,
    output logic                               flushD,
    output logic                               busy,
    output logic [$clog2(no_words+1)-1:0]      load_count,
    output logic                               err_overflow
);

    localparam int CW = $clog2(no_words + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   count_q;
    logic            err_q;
    logic            hs;
    logic            at_limit;

    assign hs       = ld_valid & ld_ready;
    // The accepting handshake is the one that brings the count up to no_words.
    assign at_limit = (count_q == CW'(no_words - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= boot_load ? LOAD : RUN;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN && load_start) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (hs) begin
                if (count_q != CW'(no_words))
                    count_q <= count_q + 1'b1;
                if (at_limit && !ld_last)
                    err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        fetch_hold = 1'b1;
        busy       = 1'b1;
        pc_reset   = 1'b0;
        flushD     = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (hs && (ld_last || at_limit))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                pc_reset  = 1'b1;
                flushD    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                fetch_hold = 1'b0;
                busy       = 1'b0;
                if (load_start)
                    state_nxt = LOAD;
            end
            default: state_nxt = boot_load ? LOAD : RUN;
        endcase
    end

    always_comb begin
        mem_we      = hs;
        mem_wr_data = ld_data;
        mem_addr    = fetch_addr;
        if (state == LOAD)
            mem_addr = address_width'(count_q) << WORD_SHIFT;
    end

    assign load_count   = count_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: three instances (64-word boot load,
// 4-word boot load, 64-word run-at-reset) driven from a shared stimulus.
module tb_imem_load_ctrl;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] fetch_addr;

    logic        m_ld_ready, m_mem_we, m_fetch_hold, m_pc_reset, m_flushD, m_busy, m_err;
    logic [31:0] m_mem_addr, m_mem_wr_data;
    logic [6:0]  m_count;

    logic        o_ld_ready, o_mem_we, o_fetch_hold, o_pc_reset, o_flushD, o_busy, o_err;
    logic [31:0] o_mem_addr, o_mem_wr_data;
    logic [2:0]  o_count;

    logic        r_ld_ready, r_mem_we, r_fetch_hold, r_pc_reset, r_flushD, r_busy, r_err;
    logic [31:0] r_mem_addr, r_mem_wr_data;
    logic [6:0]  r_count;

    int n_checks = 0;
    int n_fail   = 0;

    imem_load_ctrl #(.word_width(32), .address_width(32), .no_words(64), .boot_load(1'b1)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(m_ld_ready), .fetch_addr(fetch_addr),
        .mem_addr(m_mem_addr), .mem_we(m_mem_we), .mem_wr_data(m_mem_wr_data),
        .fetch_hold(m_fetch_hold), .pc_reset(m_pc_reset), .flushD(m_flushD), .busy(m_busy),
        .load_count(m_count), .err_overflow(m_err)
    );

    imem_load_ctrl #(.word_width(32), .address_width(32), .no_words(4), .boot_load(1'b1)) dut_ov (
        .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(o_ld_ready), .fetch_addr(fetch_addr),
        .mem_addr(o_mem_addr), .mem_we(o_mem_we), .mem_wr_data(o_mem_wr_data),
        .fetch_hold(o_fetch_hold), .pc_reset(o_pc_reset), .flushD(o_flushD), .busy(o_busy),
        .load_count(o_count), .err_overflow(o_err)
    );

    imem_load_ctrl #(.word_width(32), .address_width(32), .no_words(64), .boot_load(1'b0)) dut_run (
        .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(r_ld_ready), .fetch_addr(fetch_addr),
        .mem_addr(r_mem_addr), .mem_we(r_mem_we), .mem_wr_data(r_mem_wr_data),
        .fetch_hold(r_fetch_hold), .pc_reset(r_pc_reset), .flushD(r_flushD), .busy(r_busy),
        .load_count(r_count), .err_overflow(r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        load_start = 1'b0;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        ld_data    = '0;
        fetch_addr = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        n_checks++; if (m_ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", m_ld_ready); end
        n_checks++; if (m_fetch_hold !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_hold: got %b expected 1", m_fetch_hold); end
        n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", m_busy); end
        n_checks++; if ({m_pc_reset, m_flushD, m_mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {m_pc_reset, m_flushD, m_mem_we}); end
        n_checks++; if (m_count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", m_count); end
        n_checks++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", m_err); end
        n_checks++; if ({r_ld_ready, r_fetch_hold, r_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_run_flags: got %b expected 000", {r_ld_ready, r_fetch_hold, r_busy}); end
    endtask

    task automatic test_boot_load;
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == 2);
            #1;
            n_checks++; if (m_mem_we !== 1'b1) begin n_fail++; $display("FAIL boot_we[%0d]: got %b expected 1", i, m_mem_we); end
            n_checks++; if (m_mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL boot_addr[%0d]: got %h expected %h", i, m_mem_addr, 32'(i * 4)); end
            n_checks++; if (m_mem_wr_data !== words[i]) begin n_fail++; $display("FAIL boot_data[%0d]: got %h expected %h", i, m_mem_wr_data, words[i]); end
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_checks++; if ({m_pc_reset, m_flushD} !== 2'b11) begin n_fail++; $display("FAIL boot_drain_pulses: got %b expected 11", {m_pc_reset, m_flushD}); end
        n_checks++; if ({m_ld_ready, m_fetch_hold, m_mem_we} !== 3'b010) begin n_fail++; $display("FAIL boot_drain_flags: got %b expected 010", {m_ld_ready, m_fetch_hold, m_mem_we}); end
        n_checks++; if (m_count !== 7'd3) begin n_fail++; $display("FAIL boot_count: got %0d expected 3", m_count); end
        step();
        fetch_addr = 32'h8;
        #1;
        n_checks++; if ({m_fetch_hold, m_busy, m_pc_reset, m_flushD} !== 4'b0000) begin n_fail++; $display("FAIL boot_run_flags: got %b expected 0000", {m_fetch_hold, m_busy, m_pc_reset, m_flushD}); end
        n_checks++; if (m_mem_addr !== 32'h8) begin n_fail++; $display("FAIL boot_run_addr: got %h expected 00000008", m_mem_addr); end
        fetch_addr = 32'h124;
        #1;
        n_checks++; if (m_mem_addr !== 32'h124) begin n_fail++; $display("FAIL boot_run_addr2: got %h expected 00000124", m_mem_addr); end
    endtask

    task automatic test_overflow;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA0 + 32'(i);
            ld_last  = 1'b0;
            #1;
            if (i < 4) begin
                n_checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL ovf_write[%0d]: got we=%b addr=%h expected we=1 addr=%h", i, o_mem_we, o_mem_addr, 32'(i * 4)); end
            end else begin
                n_checks++; if (o_ld_ready !== 1'b0 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth: got ready=%b we=%b expected 0 0", o_ld_ready, o_mem_we); end
                n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", o_err); end
                n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", o_count); end
                n_checks++; if (o_pc_reset !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: got %b expected 1", o_pc_reset); end
                n_checks++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL ovf_big_err: got %b expected 0", m_err); end
            end
            step();
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if ({o_busy, o_fetch_hold, o_err} !== 3'b001) begin n_fail++; $display("FAIL ovf_run: got busy,hold,err=%b expected 001", {o_busy, o_fetch_hold, o_err}); end
    endtask

    task automatic test_reload;
        load_start = 1'b1;
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reload_before: got busy=%b expected 0", o_busy); end
        step();
        load_start = 1'b0;
        #1;
        n_checks++; if ({o_fetch_hold, o_ld_ready, o_busy} !== 3'b111) begin n_fail++; $display("FAIL reload_flags: got %b expected 111", {o_fetch_hold, o_ld_ready, o_busy}); end
        n_checks++; if (o_count !== 3'd0 || o_err !== 1'b0) begin n_fail++; $display("FAIL reload_clear: got count=%0d err=%b expected 0 0", o_count, o_err); end
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 32'h5A;
        ld_last    = 1'b0;
        #1;
        n_checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reload_w0: got we=%b addr=%h expected 1 00000000", o_mem_we, o_mem_addr); end
        step();
        load_start = 1'b0;
        ld_data    = 32'h5B;
        ld_last    = 1'b1;
        #1;
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL reload_start_in_load: got count=%0d expected 1", o_count); end
        n_checks++; if (o_mem_addr !== 32'h4 || o_mem_wr_data !== 32'h5B) begin n_fail++; $display("FAIL reload_w1: got addr=%h data=%h expected 00000004 0000005b", o_mem_addr, o_mem_wr_data); end
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_checks++; if (o_pc_reset !== 1'b1 || o_count !== 3'd2) begin n_fail++; $display("FAIL reload_drain: got pc_reset=%b count=%0d expected 1 2", o_pc_reset, o_count); end
        step();
    endtask

    task automatic test_backpressure;
        logic [4:0] pat;
        int k;
        pat = 5'b11001;
        k   = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            ld_valid = pat[i];
            ld_data  = 32'hC0 + 32'(i);
            ld_last  = (i == 4);
            #1;
            n_checks++; if (m_count !== 7'(k)) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected %0d", i, m_count, k); end
            n_checks++; if (m_mem_we !== pat[i]) begin n_fail++; $display("FAIL bp_we[%0d]: got %b expected %b", i, m_mem_we, pat[i]); end
            if (pat[i]) begin
                n_checks++; if (m_mem_addr !== 32'(k * 4)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, m_mem_addr, 32'(k * 4)); end
                k++;
            end
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_checks++; if (m_count !== 7'd3 || m_pc_reset !== 1'b1) begin n_fail++; $display("FAIL bp_end: got count=%0d pc_reset=%b expected 3 1", m_count, m_pc_reset); end
        step();
    endtask

    task automatic test_reset_mid_load;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hD0 + 32'(i);
            ld_last  = 1'b0;
            step();
        end
        reset   = 1'b1;
        ld_last = 1'b1;
        step();
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_checks++; if (m_count !== 7'd0 || m_busy !== 1'b1 || m_ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: got count=%0d busy=%b ready=%b expected 0 1 1", m_count, m_busy, m_ld_ready); end
        n_checks++; if (m_pc_reset !== 1'b0 || m_flushD !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse: got %b%b expected 00", m_pc_reset, m_flushD); end
        step();
        ld_valid = 1'b1;
        ld_data  = 32'hE0;
        #1;
        n_checks++; if (m_pc_reset !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse2: got %b expected 0", m_pc_reset); end
        n_checks++; if (m_mem_we !== 1'b1 || m_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rewrite: got we=%b addr=%h expected 1 00000000", m_mem_we, m_mem_addr); end
        step();
        ld_valid = 1'b0;
    endtask

    task automatic test_no_boot;
        apply_reset();
        ld_valid   = 1'b1;
        ld_data    = 32'hF00D;
        ld_last    = 1'b1;
        fetch_addr = 32'h44;
        #1;
        n_checks++; if (r_ld_ready !== 1'b0 || r_mem_we !== 1'b0) begin n_fail++; $display("FAIL noboot_ignore: got ready=%b we=%b expected 0 0", r_ld_ready, r_mem_we); end
        n_checks++; if (r_mem_addr !== 32'h44) begin n_fail++; $display("FAIL noboot_addr: got %h expected 00000044", r_mem_addr); end
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_checks++; if (r_count !== 7'd0 || r_busy !== 1'b0 || r_pc_reset !== 1'b0) begin n_fail++; $display("FAIL noboot_after: got count=%0d busy=%b pc_reset=%b expected 0 0 0", r_count, r_busy, r_pc_reset); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boot_load();
        test_overflow();
        test_reload();
        test_backpressure();
        test_reset_mid_load();
        test_no_boot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that owns the single-port program memory of the fetch stage and shares it between the fetch path and a streaming program loader. After reset, or on request, it holds fetch, accepts a word stream through a valid/ready handshake and writes it to consecutive word addresses. It then restarts the pipeline from address 0 with a one-cycle PC-reset/flush pulse and passes the fetch address through to the memory. It sits between the fetch stage, the program memory and the off-chip loader.

## Interface
- word_width, 32, instruction/data word width
- address_width, 32, byte address width of memory port and fetch address
- no_words, 64, memory depth in words; the load limit
- boot_load, 1, 1: enter LOAD out of reset; 0: enter RUN out of reset

- clk  in  1  clock; the block's single clock
- reset  in  1  synchronous, active-high
- load_start  in  1  request to reprogram; sampled only in RUN
- ld_valid  in  1  loader word valid
- ld_data  in  word_width  loader word
- ld_last  in  1  final word of stream, qualified by ld_valid
- ld_ready  out  1  block accepts a word this cycle
- fetch_addr  in  address_width  PC from fetch stage
- mem_addr  out  address_width  program memory byte address
- mem_we  out  1  program memory write enable
- mem_wr_data  out  word_width  program memory write data
- fetch_hold  out  1  1 = PC must not advance
- pc_reset  out  1  one-cycle pulse: reload PC to 0
- flushD  out  1  one-cycle pulse: kill decode-stage instruction
- busy  out  1  state is not RUN
- load_count  out  $clog2(no_words+1)  words written by current/last load
- err_overflow  out  1  sticky: limit reached without ld_last

## Operation
- States: LOAD, DRAIN, RUN. Reset → LOAD if boot_load, else RUN.
- LOAD: ld_ready=1, fetch_hold=1, busy=1. Handshake = ld_valid & ld_ready; on handshake mem_we=1, mem_addr=load_count<<2, mem_wr_data=ld_data; load_count increments.
- Leave LOAD for DRAIN on a handshake carrying ld_last, or on the handshake that makes load_count == no_words. If that limit handshake lacks ld_last, set err_overflow.
- DRAIN (one cycle): ld_ready=0, mem_we=0, fetch_hold=1, pc_reset=1, flushD=1 → RUN.
- RUN: mem_addr=fetch_addr, mem_we=0, ld_ready=0, fetch_hold=0, busy=0. load_start=1 → LOAD next cycle. In the same transition, load_count←0 and err_overflow←0.
- load_start is ignored outside RUN. ld_valid is ignored outside LOAD; words offered after the limit are never accepted.
- Memory indexes with mem_addr[$clog2(no_words)+1:2]. Write addresses are always word-aligned.
- Memory contents are never cleared by this block.

## Timing
- Reset values: state per boot_load; ld_ready=boot_load; fetch_hold=boot_load; busy=boot_load; pc_reset=0; flushD=0; mem_we=0; load_count=0; err_overflow=0.
- ld_ready, fetch_hold, busy, pc_reset and flushD are decoded from the state register only, so they are glitch-free from registered state.
- mem_we, mem_addr and mem_wr_data are combinational from state, handshake and fetch_addr. The write happens on the handshake edge, with zero added latency.
- A load_start sampled at edge N puts the block in LOAD after edge N. fetch_hold rises in cycle N+1, and the first word can be accepted in cycle N+1.
- The final handshake at edge M is followed by DRAIN in cycle M+1 and RUN in cycle M+2. The PC is 0 in cycle M+2.
- Single-word load (ld_last on the first word): LOAD lasts exactly one handshake cycle.
- ld_valid gaps: no write and no count change; state is held indefinitely.
- Reset asserted mid-LOAD or mid-DRAIN takes priority over everything. The block returns to its reset state the next cycle and no pulse is emitted. Words already written stay in memory.
- load_count saturates at no_words and cannot wrap.

## Structure
- Shared package imem_load_pkg: state enum (LOAD, DRAIN, RUN) and constant WORD_SHIFT=2.
- No sub-module required. The word counter and the three-state FSM are inline; the memory port mux is a single always_comb.

## Test plan
- Boot load, no_words=64: words 0x11,0x22,0x33 sent, ld_last on 0x33 → writes at mem_addr 0,4,8; load_count=3; DRAIN cycle with pc_reset=flushD=1; then RUN with fetch_hold=0 and mem_addr following fetch_addr (e.g. 0x8→0x8).
- Overflow, no_words=4: 5 words sent with no ld_last → 4 writes (addresses 0..12); err_overflow=1; 5th word sees ld_ready=0; block reaches RUN.
- Backpressure gaps: ld_valid toggled 1,0,0,1,1 → writes only on valid cycles; addresses contiguous with no holes.
- Reload from RUN: load_start pulsed → next cycle fetch_hold=1, load_count=0, err_overflow cleared. A load_start during LOAD has no effect.
- Reset mid-load after 2 of 5 words, boot_load=1 → next cycle LOAD with load_count=0; no pc_reset pulse; the next stream is written again starting at address 0.
- boot_load=0 → RUN directly out of reset; ld_ready=0 and ld_valid are ignored.
